// File: rtl/id_hazard_ctrl.sv
// ID-stage hazard controller: load-use stalls, fixed-latency MUL hold in ID,
// branch/jump squash of IF/ID, and a saturating stall-cycle counter.
module id_hazard_ctrl #(
  parameter int MUL_LATENCY = 4,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid_inst,
  input  logic [4:0]       id_ra_idx,
  input  logic [4:0]       id_rb_idx,
  input  logic             id_uses_ra,
  input  logic             id_uses_rb,
  input  logic             id_is_mul,
  input  logic             ex_valid_inst,
  input  logic             ex_rd_mem,
  input  logic [4:0]       ex_dest_reg_idx,
  input  logic             ex_take_branch,
  output logic             pc_stall,
  output logic             if_id_stall,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             mul_start,
  output logic             mul_busy,
  output logic             mul_done,
  output logic             mul_abort,
  output logic [CNT_W-1:0] stall_count
);

  typedef enum logic {RUN = 1'b0, MUL_WAIT = 1'b1} state_t;

  localparam logic [3:0] CNT_LOAD = 4'(MUL_LATENCY - 2);

  state_t           state_reg, state_next;
  logic [3:0]       cnt_reg, cnt_next;
  logic [CNT_W-1:0] stall_count_reg, stall_count_next;
  logic             ra_hit, rb_hit, luh, mul_req;

  always_comb begin
    ra_hit  = id_uses_ra && (id_ra_idx == ex_dest_reg_idx);
    rb_hit  = id_uses_rb && (id_rb_idx == ex_dest_reg_idx);
    luh     = id_valid_inst && ex_valid_inst && ex_rd_mem &&
              (ex_dest_reg_idx != 5'd0) && (ra_hit || rb_hit);
    mul_req = id_valid_inst && id_is_mul;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= RUN;
      cnt_reg         <= 4'd0;
      stall_count_reg <= '0;
    end else begin
      state_reg       <= state_next;
      cnt_reg         <= cnt_next;
      stall_count_reg <= stall_count_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    pc_stall     = 1'b0;
    if_id_stall  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    mul_start    = 1'b0;
    mul_busy     = 1'b0;
    mul_done     = 1'b0;
    mul_abort    = 1'b0;
    // Controls are held low during reset regardless of state or inputs.
    if (!rst) begin
      case (state_reg)
        RUN: begin
          if (ex_take_branch) begin
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
          end else if (luh) begin
            pc_stall     = 1'b1;
            if_id_stall  = 1'b1;
            id_ex_bubble = 1'b1;
          end else if (mul_req) begin
            mul_start    = 1'b1;
            mul_busy     = 1'b1;
            pc_stall     = 1'b1;
            if_id_stall  = 1'b1;
            id_ex_bubble = 1'b1;
            cnt_next     = CNT_LOAD;
            state_next   = MUL_WAIT;
          end
        end
        MUL_WAIT: begin
          mul_busy = 1'b1;
          if (ex_take_branch) begin
            mul_abort    = 1'b1;
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
            state_next   = RUN;
          end else if (cnt_reg != 4'd0) begin
            pc_stall     = 1'b1;
            if_id_stall  = 1'b1;
            id_ex_bubble = 1'b1;
            cnt_next     = cnt_reg - 4'd1;
          end else begin
            mul_done   = 1'b1;
            state_next = RUN;
          end
        end
        default: state_next = RUN;
      endcase
    end
  end

  always_comb begin
    stall_count_next = stall_count_reg;
    if (pc_stall && (stall_count_reg != {CNT_W{1'b1}}))
      stall_count_next = stall_count_reg + 1'b1;
  end

  assign stall_count = stall_count_reg;

endmodule

// File: tb/tb_id_hazard_ctrl.sv
// Scoreboard bench for id_hazard_ctrl: a cycle-level reference model pushes
// expected controls per cycle; a monitor pops and compares at the falling edge.
module tb_id_hazard_ctrl;

  localparam int LAT   = 4;
  localparam int CW    = 4;
  localparam int SATV  = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          id_valid_inst, id_uses_ra, id_uses_rb, id_is_mul;
  logic [4:0]    id_ra_idx, id_rb_idx, ex_dest_reg_idx;
  logic          ex_valid_inst, ex_rd_mem, ex_take_branch;
  logic          pc_stall, if_id_stall, if_id_flush, id_ex_bubble;
  logic          mul_start, mul_busy, mul_done, mul_abort;
  logic [CW-1:0] stall_count;

  always #5 clk = ~clk;

  id_hazard_ctrl #(.MUL_LATENCY(LAT), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .id_valid_inst(id_valid_inst), .id_ra_idx(id_ra_idx), .id_rb_idx(id_rb_idx),
    .id_uses_ra(id_uses_ra), .id_uses_rb(id_uses_rb), .id_is_mul(id_is_mul),
    .ex_valid_inst(ex_valid_inst), .ex_rd_mem(ex_rd_mem),
    .ex_dest_reg_idx(ex_dest_reg_idx), .ex_take_branch(ex_take_branch),
    .pc_stall(pc_stall), .if_id_stall(if_id_stall), .if_id_flush(if_id_flush),
    .id_ex_bubble(id_ex_bubble), .mul_start(mul_start), .mul_busy(mul_busy),
    .mul_done(mul_done), .mul_abort(mul_abort), .stall_count(stall_count)
  );

  // ctl order: pc_stall, if_id_stall, if_id_flush, id_ex_bubble,
  //            mul_start, mul_busy, mul_done, mul_abort
  typedef struct packed {
    logic [7:0]    ctl;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  // Reference model: cycles since the MUL started (-1 when no MUL in flight).
  int   mul_age  = -1;
  int   ref_cnt  = 0;

  task automatic step();
    exp_t e;
    logic s, fs, fl, bb, st, bz, dn, ab, hz;
    s = 0; fs = 0; fl = 0; bb = 0; st = 0; bz = 0; dn = 0; ab = 0;
    hz = id_valid_inst && ex_valid_inst && ex_rd_mem && (ex_dest_reg_idx != 0) &&
         ((id_uses_ra && id_ra_idx == ex_dest_reg_idx) ||
          (id_uses_rb && id_rb_idx == ex_dest_reg_idx));
    e.cnt = CW'(ref_cnt);
    if (rst) begin
      mul_age = -1;
    end else if (mul_age >= 0) begin
      bz = 1;
      if (ex_take_branch) begin
        ab = 1; fl = 1; bb = 1; mul_age = -1;
      end else if (mul_age == LAT - 1) begin
        dn = 1; mul_age = -1;
      end else begin
        s = 1; fs = 1; bb = 1; mul_age++;
      end
    end else if (ex_take_branch) begin
      fl = 1; bb = 1;
    end else if (hz) begin
      s = 1; fs = 1; bb = 1;
    end else if (id_valid_inst && id_is_mul) begin
      st = 1; bz = 1; s = 1; fs = 1; bb = 1; mul_age = 1;
    end
    e.ctl = {s, fs, fl, bb, st, bz, dn, ab};
    exp_q.push_back(e);
    if (rst) ref_cnt = 0;
    else if (s && ref_cnt < SATV) ref_cnt++;
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle(input logic r);
    rst = r;
    id_valid_inst = 0; id_uses_ra = 0; id_uses_rb = 0; id_is_mul = 0;
    id_ra_idx = 0; id_rb_idx = 0;
    ex_valid_inst = 0; ex_rd_mem = 0; ex_dest_reg_idx = 0; ex_take_branch = 0;
  endtask

  task automatic set_luh(input logic [4:0] d);
    id_valid_inst = 1; id_uses_ra = 1; id_ra_idx = 5'd5;
    ex_valid_inst = 1; ex_rd_mem = 1; ex_dest_reg_idx = d;
  endtask

  task automatic set_mul();
    id_valid_inst = 1; id_is_mul = 1;
  endtask

  // Monitor: every cycle the DUT presents a full set of controls.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        cyc++;
        checks++;
        if ({pc_stall, if_id_stall, if_id_flush, id_ex_bubble,
             mul_start, mul_busy, mul_done, mul_abort} !== e.ctl) begin
          errors++;
          $display("FAIL ctl cyc=%0d got=%b want=%b", cyc,
                   {pc_stall, if_id_stall, if_id_flush, id_ex_bubble,
                    mul_start, mul_busy, mul_done, mul_abort}, e.ctl);
        end
        checks++;
        if (stall_count !== e.cnt) begin
          errors++;
          $display("FAIL stall_count cyc=%0d got=%0d want=%0d", cyc, stall_count, e.cnt);
        end
        $display("cyc %0d ctl=%b cnt=%0d", cyc, e.ctl, e.cnt);
      end
    end
  end

  initial begin
    int wait_cyc;
    set_idle(1'b1);
    @(posedge clk); #1;
    step(); step();

    // Load-use with a real destination, then with x0.
    set_idle(0); set_luh(5'd5); step();
    set_idle(0); step();
    set_luh(5'd0); step();
    set_idle(0); step();

    // Single MUL held in ID for LAT cycles, then back-to-back pair.
    set_mul(); repeat (LAT) step();
    set_idle(0); step();
    set_mul(); repeat (2 * LAT) step();
    set_idle(0); step();

    // Branch beats load-use and MUL request.
    set_luh(5'd5); set_mul(); id_uses_ra = 1; ex_take_branch = 1; step();
    set_idle(0); step();

    // Abort on second cycle of MUL_WAIT.
    set_mul(); step(); step();
    ex_take_branch = 1; step();
    set_idle(0); step();

    // Reset mid-MUL, then a fresh full MUL.
    set_mul(); step(); step();
    rst = 1; step();
    rst = 0; repeat (LAT + 1) step();
    set_idle(0); step();

    // Saturation of the stall counter.
    set_luh(5'd5); repeat (20) step();
    set_idle(0); step();

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      rst             = ($urandom_range(0, 99) < 3);
      id_valid_inst   = ($urandom_range(0, 9) < 8);
      id_is_mul       = ($urandom_range(0, 3) == 0);
      id_uses_ra      = $urandom_range(0, 1);
      id_uses_rb      = $urandom_range(0, 1);
      id_ra_idx       = 5'($urandom_range(0, 3));
      id_rb_idx       = 5'($urandom_range(0, 3));
      ex_valid_inst   = ($urandom_range(0, 9) < 8);
      ex_rd_mem       = $urandom_range(0, 1);
      ex_dest_reg_idx = 5'($urandom_range(0, 3));
      ex_take_branch  = ($urandom_range(0, 9) == 0);
      step();
    end
    set_idle(0);

    wait_cyc = 0;
    while (exp_q.size() != 0 && wait_cyc < 10) begin
      @(posedge clk);
      wait_cyc++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got=%0d pending want=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
